lzc_seq_ctrl: RTL
=================

# lzc_seq_ctrl

Iterative leading-zero-count sequencer. It scans a WIDTH-bit word from the MSB, two bits per cycle, through a single shared 2-bit LZC leaf instance with outputs p and v. It accumulates the count and returns it over a valid/ready handshake. It sits in front of the approximate-FP normalisation shifter where area matters more than latency.

## Interface

- WIDTH, 32: input word width. Must be even and ≥4.
- CW, $clog2(WIDTH+1): count width (derived, not overridden).

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request carries a word
- in_ready  out  1  controller can accept (high only in IDLE)
- in_data  in  WIDTH  word to count
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_count  out  CW  leading-zero count, 0..WIDTH
- out_zero  out  1  input word was all zeros (out_count == WIDTH)

## Operation

- States: IDLE, SCAN, DONE. Reset → IDLE, pair index k=0, count register 0, hit flag 0, out_valid=0, out_count=0, out_zero=0, in_ready=1.
- IDLE: in_ready=1. On in_valid, capture in_data into a shift register, clear k and the hit flag, and go to SCAN.
- SCAN: in_ready=0.
  - Pair k covers in_data[WIDTH-1-2k] (upper) and in_data[WIDTH-2-2k] (lower).
  - Leaf input b[0]=upper, b[1]=lower. Leaf gives p = !b[0] and v = b[0]|b[1].
  - First pair with v=1 (hit flag clear): count ← 2k+p, set hit flag.
  - Last pair (k = WIDTH/2−1) with no hit so far: count ← WIDTH, out_zero ← 1.
  - k increments by 1 per SCAN cycle. Its width is $clog2(WIDTH/2) and it never wraps: SCAN exits at the last pair.
- Exit from SCAN to DONE: on a hit (early exit, see Configuration) or after evaluating the last pair.
- DONE: out_valid=1. out_count and out_zero hold stable until out_ready=1. On that handshake go to IDLE.
- The result holds for any number of out_ready-low cycles. in_data changes during SCAN/DONE are ignored because the word is captured.
- A new request is accepted no earlier than the cycle after the output handshake. There is no overlap.
- rst in any state returns everything to reset values on the next edge. An in-flight result is discarded and not emitted.
- Arithmetic: 2k+p is computed at CW bits. The maximum hit value is WIDTH−1 and all-zero gives WIDTH, so no overflow.

## Timing

- Cycle 0 is the edge where in_valid & in_ready. Pair k is evaluated in cycle k+1.
- Early exit: a hit at pair k puts out_valid high from cycle k+2. Best case 2 cycles; all-zero case WIDTH/2+1 cycles.
- Fixed schedule: out_valid rises in cycle WIDTH/2+1 regardless of data.
- Outputs are registered. No combinational path from in_* to out_*, or from out_ready to in_ready.
- Throughput is one word per (latency+1) cycles with out_ready held high.

## Configuration

- LZC_SEQ_EARLY_EXIT_EN defined: SCAN goes to DONE in the same cycle the first hit is recorded. Latency is data-dependent.
- LZC_SEQ_EARLY_EXIT_EN undefined: SCAN always walks all WIDTH/2 pairs. The hit flag makes the first hit sticky, so later pairs never overwrite count. Latency is constant WIDTH/2+1.
- out_count and out_zero values are identical in both builds.

## Test plan

- WIDTH=8, in_data=8'b0001_0110, early exit → out_count=3, out_zero=0, out_valid at cycle 3. Without the macro, same values at cycle 5.
- WIDTH=8, in_data=8'h80 → out_count=0 at cycle 2 (early exit). With 8'h40 → out_count=1 at cycle 2.
- WIDTH=8, in_data=8'h00 → out_count=8, out_zero=1, out_valid at cycle 5 in both builds.
- Backpressure: in_data=8'h01 (out_count=7), out_ready low for 3 cycles after out_valid → result stable and in_ready=0 throughout. Handshake then IDLE, with in_ready=1 the next cycle.
- rst asserted in cycle 2 of a scan of 8'h00 → next cycle IDLE, out_valid=0, out_count=0, in_ready=1. A following request for 8'h20 returns out_count=2.
- Random sweep: 1000 words at WIDTH=32 with random out_ready → out_count matches a reference count of leading zeros, and exactly one result per accepted request.

Source files
------------

// File: rtl/lzc_seq_ctrl.sv
// lzc_seq_ctrl: iterative leading-zero counter scanning two bits per cycle through one shared 2-bit leaf
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data request side;
//        out_valid/out_ready/out_count/out_zero result side (all outputs registered).
// Build option: LZC_SEQ_EARLY_EXIT_EN ends the scan on the first hit; otherwise all WIDTH/2 pairs are walked.
module lzc_seq_leaf2 (
  input  logic [1:0] b,
  output logic       p,
  output logic       v
);
  assign p = !b[0];
  assign v = b[0] | b[1];
endmodule

module lzc_seq_ctrl #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);
  localparam int KW = $clog2(WIDTH / 2);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH / 2 - 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hit_q, hit_d, zero_q, zero_d;
  logic p, v, last, first_hit;
  logic [CW-1:0] pair_cnt;
  // the word shifts left two bits per cycle, so the current pair always sits at the top
  lzc_seq_leaf2 u_leaf (.b({sh_q[WIDTH-2], sh_q[WIDTH-1]}), .p(p), .v(v));
  assign last      = k_q == K_LAST;
  assign first_hit = v && !hit_q;
  assign pair_cnt  = CW'({k_q, 1'b0}) + CW'(p);
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    zero_d  = zero_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        sh_d    = in_data;
        k_d     = '0;
        hit_d   = 1'b0;
        cnt_d   = '0;
        zero_d  = 1'b0;
        state_d = SCAN;
      end
    end else if (state_q == SCAN) begin
      sh_d = sh_q << 2;
      k_d  = last ? k_q : k_q + KW'(1);
      if (first_hit) begin
        cnt_d = pair_cnt;
        hit_d = 1'b1;
      end
      if (last && !hit_q && !v) begin
        cnt_d  = CW'(WIDTH);
        zero_d = 1'b1;
      end
`ifdef LZC_SEQ_EARLY_EXIT_EN
      state_d = (last || first_hit) ? DONE : SCAN;
`else
      state_d = last ? DONE : SCAN;
`endif
    end else begin
      state_d = out_ready ? IDLE : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      zero_q  <= zero_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_count = cnt_q;
  assign out_zero  = zero_q;
endmodule
